// File: rtl/clkdiv_pkg.sv
// Shared constants and FSM encoding for the clock dividers and their monitor.
package clkdiv_pkg;

  // Default division ratio and counter width used by the dividers and the monitor.
  localparam int DIV_DEFAULT      = 3;
  localparam int CW_DEFAULT       = 4;

  // Default monitor qualification settings.
  localparam int LOCK_CNT_DEFAULT = 4;
  localparam int DUTY_TOL_DEFAULT = 1;
  localparam int TIMEOUT_DEFAULT  = 8;

  // Monitor FSM states; the encoding is visible to status registers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_LOCK = 2'd3
  } mon_state_t;

endpackage

// File: rtl/clk_div_edge_sync.sv
// Two-flop synchronizer plus a delay flop for rise/fall detection of an
// asynchronous divided clock sampled in the clk domain.
module clk_div_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronize the input and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_d;
  assign fall  = ~sync & sync_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock: measures period and high time in
// clk cycles, qualifies them against DIV, and reports lock, error and stall.
module clk_div_monitor #(
  parameter int DIV      = clkdiv_pkg::DIV_DEFAULT,
  parameter int CW       = clkdiv_pkg::CW_DEFAULT,
  parameter int LOCK_CNT = clkdiv_pkg::LOCK_CNT_DEFAULT,
  parameter int DUTY_TOL = clkdiv_pkg::DUTY_TOL_DEFAULT,
  parameter int TIMEOUT  = clkdiv_pkg::TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_div_clk,
  input  logic          i_enable,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high,
  output logic          o_meas_valid,
  output logic          o_locked,
  output logic          o_err,
  output logic          o_stall,
  output logic [7:0]    o_err_cnt
);

  import clkdiv_pkg::*;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] DIV_VAL     = CW'(DIV);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);
  localparam logic [CW+1:0] TOL_VAL     = (CW+2)'(DUTY_TOL);
  localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] LOCK_FULL   = GW'(LOCK_CNT);

  mon_state_t state;
  mon_state_t next_state;

  logic          level;
  logic          rise;
  // High time is counted from the synchronized level, so the falling edge is not needed here.
  logic          fall_unused;

  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;
  logic [GW-1:0] goodcnt;

  logic          run;
  logic          take_meas;
  logic          stall_hit;
  logic          stall_cond;
  logic          good;

  logic signed [CW+1:0] duty_diff;
  logic        [CW+1:0] duty_abs;

  clk_div_edge_sync u_edge_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (i_div_clk),
    .level  (level),
    .rise   (rise),
    .fall   (fall_unused)
  );

  // A period is good when it matches DIV and the duty error |2*high - period| is within tolerance.
  always_comb begin
    duty_diff = $signed({1'b0, hcnt, 1'b0}) - $signed({2'b00, cnt});
    duty_abs  = duty_diff[CW+1] ? $unsigned(-duty_diff) : $unsigned(duty_diff);
    good      = (cnt == DIV_VAL) && (duty_abs <= TOL_VAL);
  end

  assign stall_cond = (cnt >= TIMEOUT_VAL);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and event decode; disable beats rise, and rise beats timeout.
  always_comb begin
    next_state = state;
    run        = 1'b0;
    take_meas  = 1'b0;
    stall_hit  = 1'b0;
    if (!i_enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          next_state = ST_ARM;
        end
        ST_ARM: begin
          run = 1'b1;
          if (rise) begin
            next_state = ST_MEAS;
          end else if (stall_cond) begin
            stall_hit = 1'b1;
          end
        end
        ST_MEAS: begin
          run = 1'b1;
          if (rise) begin
            take_meas = 1'b1;
            if (good && (goodcnt >= LOCK_LAST)) begin
              next_state = ST_LOCK;
            end
          end else if (stall_cond) begin
            stall_hit  = 1'b1;
            next_state = ST_ARM;
          end
        end
        ST_LOCK: begin
          run = 1'b1;
          if (rise) begin
            take_meas = 1'b1;
            if (!good) begin
              next_state = ST_MEAS;
            end
          end else if (stall_cond) begin
            stall_hit  = 1'b1;
            next_state = ST_ARM;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Period and high-time counters; both restart at 1 on every rise and saturate.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (!run) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CW'(1);
      hcnt <= CW'(1);
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (level && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  // Status registers: measurement capture, lock qualification, error and stall reporting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_period     <= '0;
      o_high       <= '0;
      o_meas_valid <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_stall      <= 1'b0;
      o_err_cnt    <= '0;
      goodcnt      <= '0;
    end else begin
      o_meas_valid <= 1'b0;
      o_err        <= 1'b0;
      if (!run) begin
        goodcnt  <= '0;
        o_locked <= 1'b0;
        o_stall  <= 1'b0;
      end else begin
        if (rise) begin
          o_stall <= 1'b0;
        end
        if (take_meas) begin
          o_period     <= cnt;
          o_high       <= hcnt;
          o_meas_valid <= 1'b1;
          if (good) begin
            if (goodcnt != LOCK_FULL) begin
              goodcnt <= goodcnt + GW'(1);
            end
            if (goodcnt >= LOCK_LAST) begin
              o_locked <= 1'b1;
            end
          end else begin
            o_err    <= 1'b1;
            goodcnt  <= '0;
            o_locked <= 1'b0;
            if (o_err_cnt != 8'hFF) begin
              o_err_cnt <= o_err_cnt + 8'd1;
            end
          end
        end else if (stall_hit) begin
          o_stall  <= 1'b1;
          o_locked <= 1'b0;
          goodcnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a programmable divided-clock generator
// drives i_div_clk while the checks compare outputs against hand-derived values.
module tb_clk_div_monitor;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_div_clk = 1'b0;
  logic          i_enable;
  logic [CW-1:0] o_period;
  logic [CW-1:0] o_high;
  logic          o_meas_valid;
  logic          o_locked;
  logic          o_err;
  logic          o_stall;
  logic [7:0]    o_err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_meas_cyc = 0;

  // Generator settings, picked up at the start of each generated period.
  int gen_per = 3;
  int gen_hi  = 1;
  int cur_per = 3;
  int cur_hi  = 1;
  int phase   = 0;

  clk_div_monitor #(
    .DIV      (3),
    .CW       (CW),
    .LOCK_CNT (4),
    .DUTY_TOL (1),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_div_clk    (i_div_clk),
    .i_enable     (i_enable),
    .o_period     (o_period),
    .o_high       (o_high),
    .o_meas_valid (o_meas_valid),
    .o_locked     (o_locked),
    .o_err        (o_err),
    .o_stall      (o_stall),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter used for spacing and stall-latency checks.
  always @(posedge clk) cyc++;

  // Remember when the last measurement was reported.
  always @(negedge clk) if (o_meas_valid) last_meas_cyc = cyc;

  // Divided-clock generator, changing only on the falling clk edge.
  always @(negedge clk) begin
    if (phase == 0) begin
      cur_per = gen_per;
      cur_hi  = gen_hi;
    end
    i_div_clk = (phase < cur_hi);
    phase = (phase + 1 >= cur_per) ? 0 : phase + 1;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int per, input int hi);
    @(posedge clk);
    gen_per = per;
    gen_hi  = hi;
  endtask

  task automatic waitMeas(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_meas_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput({tag, " timeout"}, 0, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " period"}, o_period, 0);
    checkOutput({tag, " high"}, o_high, 0);
    checkOutput({tag, " valid"}, o_meas_valid, 0);
    checkOutput({tag, " locked"}, o_locked, 0);
    checkOutput({tag, " err"}, o_err, 0);
    checkOutput({tag, " stall"}, o_stall, 0);
    checkOutput({tag, " err_cnt"}, o_err_cnt, 0);
  endtask

  // Relock sequence: four good periods, lock asserted on the fourth.
  task automatic checkRelock(input string tag, input int hi, input int err_cnt);
    bit got;
    for (int k = 0; k < 4; k++) begin
      waitMeas(tag, got);
      checkOutput({tag, " period"}, o_period, 3);
      checkOutput({tag, " high"}, o_high, hi);
      checkOutput({tag, " err"}, o_err, 0);
      checkOutput({tag, " err_cnt"}, o_err_cnt, err_cnt);
      checkOutput({tag, " locked"}, o_locked, (k == 3) ? 1 : 0);
    end
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got;
    int prev;
    int valids;
    int n;

    resetn   = 1'b0;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");

    // Test 1: steady div-by-3 with high time 1.
    resetn   = 1'b1;
    i_enable = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      waitMeas("t1 meas", got);
      checkOutput("t1 period", o_period, 3);
      checkOutput("t1 high", o_high, 1);
      checkOutput("t1 err", o_err, 0);
      checkOutput("t1 locked", o_locked, (k >= 3) ? 1 : 0);
      if (k > 0) checkOutput("t1 spacing", cyc - prev, 3);
      prev = cyc;
    end

    // Test 2: period 4 (high 2) after lock, then back to period 3 (high 2).
    applyStimulus(4, 2);
    for (int k = 0; k < 6; k++) begin
      waitMeas("t2 find", got);
      if (o_period != 3) break;
    end
    checkOutput("t2 period", o_period, 4);
    checkOutput("t2 high", o_high, 2);
    checkOutput("t2 err", o_err, 1);
    checkOutput("t2 locked", o_locked, 0);
    checkOutput("t2 err_cnt", o_err_cnt, 1);
    applyStimulus(3, 2);
    waitMeas("t2 second", got);
    checkOutput("t2 second period", o_period, 4);
    checkOutput("t2 second err_cnt", o_err_cnt, 2);
    checkRelock("t2 relock", 2, 2);

    // Test 3: input stuck low after lock, then recovery.
    applyStimulus(3, 0);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_stall) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("t3 stall seen", got, 1);
    checkOutput("t3 stall latency", cyc - last_meas_cyc, 8);
    checkOutput("t3 locked", o_locked, 0);
    checkOutput("t3 err_cnt", o_err_cnt, 2);
    applyStimulus(3, 2);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!o_stall) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("t3 stall cleared", got, 1);
    checkOutput("t3 no meas on rearm", o_meas_valid, 0);
    checkRelock("t3 relock", 2, 2);

    // Test 4: bad periods (period 5, high 4) until the error counter saturates.
    applyStimulus(5, 4);
    for (int k = 0; k < 6; k++) begin
      waitMeas("t4 find", got);
      if (o_period == 5) break;
    end
    checkOutput("t4 first err", o_err, 1);
    checkOutput("t4 first locked", o_locked, 0);
    checkOutput("t4 first err_cnt", o_err_cnt, 3);
    for (n = 2; n <= 260; n++) begin
      waitMeas("t4 meas", got);
      if (n == 252) checkOutput("t4 err_cnt 254", o_err_cnt, 254);
      if (n == 253) checkOutput("t4 err_cnt 255", o_err_cnt, 255);
    end
    checkOutput("t4 sat err_cnt", o_err_cnt, 255);
    checkOutput("t4 sat err pulse", o_err, 1);
    checkOutput("t4 sat period", o_period, 5);
    checkOutput("t4 sat high", o_high, 4);

    // Test 5: one-cycle reset while locked.
    applyStimulus(3, 1);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      waitMeas("t5 lock", prev[0]);
      if (o_locked) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("t5 locked before reset", got, 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkAllZero("t5 reset");
    resetn = 1'b1;
    checkRelock("t5 relock", 1, 0);

    // Test 6: enable dropped mid-period, raised again 5 cycles later.
    @(negedge clk);
    i_enable = 1'b0;
    valids = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_meas_valid) valids++;
      if (i == 1) checkOutput("t6 locked drop", o_locked, 0);
    end
    checkOutput("t6 no meas while off", valids, 0);
    checkOutput("t6 period held", o_period, 3);
    checkOutput("t6 err_cnt held", o_err_cnt, 0);
    i_enable = 1'b1;
    checkRelock("t6 relock", 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
